// File: rtl/fano_branch_buffer.sv
// Circular branch store feeding the Fano decoder: captures depunctured branches and serves them
// through a read pointer that moves forward on extend and backward on backtrack.
module fano_branch_buffer #(
    parameter int unsigned D_WIDTH    = 2,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_clr,
    input  logic                  i_vld,
    input  logic [D_WIDTH-1:0]    i_data,
    input  logic                  i_fwd,
    input  logic                  i_back,
    input  logic                  i_release,
    output logic                  o_vld,
    output logic [D_WIDTH-1:0]    o_data,
    output logic [DEPTH_LOG2:0]   o_fill,
    output logic [DEPTH_LOG2:0]   o_depth,
    output logic                  o_full,
    output logic                  o_ovf,
    output logic                  o_cmd_err
);

    localparam int unsigned          NUM_ENTRIES = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]  DEPTH_P     = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]  ONE_P       = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [D_WIDTH-1:0] mem [0:NUM_ENTRIES-1];

    logic [DEPTH_LOG2:0] wr_q, wr_d, rd_q, rd_d, tail_q, tail_d;
    logic [DEPTH_LOG2:0] fill_q, fill_d, depth_q, depth_d;
    logic                vld_q, vld_d, full_q, full_d, ovf_q, ovf_d, err_q, err_d;
    logic [D_WIDTH-1:0]  data_q, data_d;

    logic full, wr_en, fwd_ok, back_raw, back_clash, back_ok, rel_ok, cmd_err;

    always_comb begin
        full       = (wr_q - tail_q) == DEPTH_P;
        wr_en      = i_vld && !full && !i_clr;
        fwd_ok     = i_fwd && !i_back && (rd_q != wr_q);
        back_raw   = i_back && !i_fwd && (rd_q != tail_q);
        rel_ok     = i_release && (tail_q != rd_q);
        // Stepping back onto the entry being released would leave rd behind tail.
        back_clash = back_raw && rel_ok && ((rd_q - tail_q) == ONE_P);
        back_ok    = back_raw && !back_clash;
        cmd_err    = (i_fwd && i_back)
                   || (i_fwd && !i_back && (rd_q == wr_q))
                   || (i_back && !i_fwd && (rd_q == tail_q))
                   || (i_release && (tail_q == rd_q))
                   || back_clash;
    end

    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        tail_d = tail_q;
        ovf_d  = ovf_q;
        err_d  = 1'b0;
        data_d = data_q;
        if (i_clr) begin
            wr_d   = '0;
            rd_d   = '0;
            tail_d = '0;
            ovf_d  = 1'b0;
            data_d = '0;
        end else begin
            if (wr_en)   wr_d   = wr_q + ONE_P;
            if (fwd_ok)  rd_d   = rd_q + ONE_P;
            if (back_ok) rd_d   = rd_q - ONE_P;
            if (rel_ok)  tail_d = tail_q + ONE_P;
            if (i_vld && full) ovf_d = 1'b1;
            err_d = cmd_err;
        end
        vld_d   = rd_d != wr_d;
        fill_d  = wr_d - tail_d;
        depth_d = rd_d - tail_d;
        full_d  = fill_d == DEPTH_P;
        if (vld_d) begin
            // A branch written this edge into the slot under rd bypasses the array.
            if (wr_en && (wr_q[DEPTH_LOG2-1:0] == rd_d[DEPTH_LOG2-1:0])) begin
                data_d = i_data;
            end else begin
                data_d = mem[rd_d[DEPTH_LOG2-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_q[DEPTH_LOG2-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            tail_q  <= '0;
            fill_q  <= '0;
            depth_q <= '0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            tail_q  <= tail_d;
            fill_q  <= fill_d;
            depth_q <= depth_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign o_vld     = vld_q;
    assign o_data    = data_q;
    assign o_fill    = fill_q;
    assign o_depth   = depth_q;
    assign o_full    = full_q;
    assign o_ovf     = ovf_q;
    assign o_cmd_err = err_q;

endmodule
